// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// select encodings, FSM states and the decoded control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] J_SEQ  = 2'b00;
    localparam logic [1:0] J_JUMP = 2'b01;
    localparam logic [1:0] J_REG  = 2'b10;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_t;

    typedef enum logic [3:0] {
        KindIllegal, KindJ, KindJal, KindJr, KindRtype, KindBeq, KindImm, KindLw, KindSw
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [1:0] reg_dst;
        logic       write_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic [1:0] j_sel;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_decoder.sv
// Combinational opcode/funct decode into the controller's instruction class and
// datapath select word; unknown encodings come out as KindIllegal.
module mips_decoder
    import mips_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t c;

    always_comb begin
        c      = '0;
        c.kind = KindIllegal;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst = REGDST_RD;
                case (funct)
                    FN_ADD: begin c.kind = KindRtype; c.alu_ctrl = ALU_ADD; end
                    FN_SUB: begin c.kind = KindRtype; c.alu_ctrl = ALU_SUB; end
                    FN_AND: begin c.kind = KindRtype; c.alu_ctrl = ALU_AND; end
                    FN_OR:  begin c.kind = KindRtype; c.alu_ctrl = ALU_OR;  end
                    FN_SLT: begin c.kind = KindRtype; c.alu_ctrl = ALU_SLT; end
                    FN_JR:  begin c.kind = KindJr;    c.j_sel    = J_REG;   end
                    default: c.kind = KindIllegal;
                endcase
            end
            OP_J: begin
                c.kind  = KindJ;
                c.j_sel = J_JUMP;
            end
            OP_JAL: begin
                c.kind      = KindJal;
                c.reg_dst   = REGDST_R31;
                c.write_dst = 1'b1;
                c.j_sel     = J_JUMP;
            end
            OP_BEQ: begin
                c.kind     = KindBeq;
                c.alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                c.kind     = KindImm;
                c.alu_src  = 1'b1;
                c.alu_ctrl = ALU_ADD;
            end
            OP_SLTI: begin
                c.kind     = KindImm;
                c.alu_src  = 1'b1;
                c.alu_ctrl = ALU_SLT;
            end
            OP_LW: begin
                c.kind       = KindLw;
                c.alu_src    = 1'b1;
                c.alu_ctrl   = ALU_ADD;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.kind     = KindSw;
                c.alu_src  = 1'b1;
                c.alu_ctrl = ALU_ADD;
            end
            default: c.kind = KindIllegal;
        endcase
        ctrl = c;
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS sequencer: FSM, memory handshakes with timeout, registered control outputs.
// Outputs are registered from next-state; only the sw commit strobe follows dmem_ack directly.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_rd,
    output logic       dmem_wr,
    output logic       pc_en,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       write_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [2:0] alu_ctrl,
    output logic       pc_src,
    output logic [1:0] J,
    output logic       halted,
    output logic       bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] ir_q;
    logic        timeout;
    logic        fetch_accept;
    logic [5:0]  dec_op, dec_fn;
    logic [CTRL_W-1:0] ctrl_bits;
    ctrl_t       ctrl;

    logic imem_req_d, dmem_rd_d, dmem_wr_d, pc_en_d, pc_en_q, reg_write_d;

    assign fetch_accept = (state_q == StFetch) && imem_req && imem_ack;
    // The word being accepted is decoded straight from the bus so DECODE outputs are ready on entry.
    assign dec_op = fetch_accept ? opcode : ir_q[11:6];
    assign dec_fn = fetch_accept ? funct  : ir_q[5:0];

    mips_decoder u_decoder (
        .opcode (dec_op),
        .funct  (dec_fn),
        .ctrl   (ctrl_bits)
    );

    assign ctrl = ctrl_t'(ctrl_bits);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        case (state_q)
            StFetch: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        state_d = StDecode;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StHalt;
                        timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StDecode: begin
                case (ctrl.kind)
                    KindIllegal:  state_d = StHalt;
                    KindJ, KindJal: state_d = StFetch;
                    default:      state_d = StExec;
                endcase
            end
            StExec: begin
                case (ctrl.kind)
                    KindRtype, KindImm: state_d = StWb;
                    KindJr, KindBeq:    state_d = StFetch;
                    KindLw, KindSw:     state_d = StMem;
                    default:            state_d = StHalt;
                endcase
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = (ctrl.kind == KindSw) ? StFetch : StWb;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StHalt;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb:    state_d = StFetch;
            default: state_d = StHalt;
        endcase
        if ((state_d == StFetch || state_d == StMem) && state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        imem_req_d  = (state_d == StFetch);
        dmem_rd_d   = (state_d == StMem) && (ctrl.kind == KindLw);
        dmem_wr_d   = (state_d == StMem) && (ctrl.kind == KindSw);
        pc_en_d     = ((state_d == StDecode) && (ctrl.kind == KindJ || ctrl.kind == KindJal)) ||
                      ((state_d == StExec) && (ctrl.kind == KindBeq || ctrl.kind == KindJr)) ||
                      (state_d == StWb);
        reg_write_d = ((state_d == StDecode) && (ctrl.kind == KindJal)) || (state_d == StWb);
    end

    assign pc_en = pc_en_q || ((state_q == StMem) && (ctrl.kind == KindSw) && dmem_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFetch;
            cnt_q      <= '0;
            ir_q       <= '0;
            imem_req   <= 1'b0;
            dmem_rd    <= 1'b0;
            dmem_wr    <= 1'b0;
            pc_en_q    <= 1'b0;
            reg_write  <= 1'b0;
            reg_dst    <= '0;
            write_dst  <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            alu_ctrl   <= '0;
            pc_src     <= 1'b0;
            J          <= '0;
            halted     <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            imem_req  <= imem_req_d;
            dmem_rd   <= dmem_rd_d;
            dmem_wr   <= dmem_wr_d;
            pc_en_q   <= pc_en_d;
            reg_write <= reg_write_d;
            halted    <= halted || (state_d == StHalt);
            bus_err   <= bus_err || timeout;
            if (fetch_accept) begin
                ir_q       <= {opcode, funct};
                reg_dst    <= ctrl.reg_dst;
                write_dst  <= ctrl.write_dst;
                mem_to_reg <= ctrl.mem_to_reg;
                alu_src    <= ctrl.alu_src;
                alu_ctrl   <= ctrl.alu_ctrl;
                J          <= ctrl.j_sel;
                pc_src     <= 1'b0;
            end
            // zero reflects the sub issued during DECODE.
            if (state_q == StDecode && state_d == StExec && ctrl.kind == KindBeq) begin
                pc_src <= zero;
            end
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench: per-instruction cycle timeline derived from latency rules, checked every cycle.
module tb_mips_mc_controller;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, dmem_rd, dmem_wr, pc_en, reg_write;
    logic [1:0] reg_dst, J;
    logic       write_dst, mem_to_reg, alu_src, pc_src, halted, bus_err;
    logic [2:0] alu_ctrl;

    mips_mc_controller #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .pc_en      (pc_en),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .write_dst  (write_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .J          (J),
        .halted     (halted),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectations for the current cycle, published by the stimulus and checked at negedge.
    logic       exp_valid = 1'b0;
    logic       exp_imem_req, exp_dmem_rd, exp_dmem_wr, exp_pc_en, exp_reg_write;
    logic       exp_halted, exp_bus_err;
    logic       exp_sel, exp_chk_rd, exp_chk_alu;
    logic [1:0] exp_reg_dst, exp_j;
    logic       exp_write_dst, exp_m2r, exp_alu_src, exp_pc_src;
    logic [2:0] exp_alu;

    always @(negedge clk) begin
        if (exp_valid) begin
            check("imem_req",  8'(imem_req),  8'(exp_imem_req));
            check("dmem_rd",   8'(dmem_rd),   8'(exp_dmem_rd));
            check("dmem_wr",   8'(dmem_wr),   8'(exp_dmem_wr));
            check("pc_en",     8'(pc_en),     8'(exp_pc_en));
            check("reg_write", 8'(reg_write), 8'(exp_reg_write));
            check("halted",    8'(halted),    8'(exp_halted));
            check("bus_err",   8'(bus_err),   8'(exp_bus_err));
            if (exp_sel) begin
                check("J",          8'(J),          8'(exp_j));
                check("pc_src",     8'(pc_src),     8'(exp_pc_src));
                check("alu_src",    8'(alu_src),    8'(exp_alu_src));
                check("mem_to_reg", 8'(mem_to_reg), 8'(exp_m2r));
                if (exp_chk_rd) begin
                    check("reg_dst",   8'(reg_dst),   8'(exp_reg_dst));
                    check("write_dst", 8'(write_dst), 8'(exp_write_dst));
                end
                if (exp_chk_alu) check("alu_ctrl", 8'(alu_ctrl), 8'(exp_alu));
            end
        end
    end

    // Classes: 0 illegal, 1 j, 2 jal, 3 jr, 4 R-type, 5 beq, 6 addi/slti, 7 lw, 8 sw.
    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return 4;
                6'h08: return 3;
                default: return 0;
            endcase
            6'h02: return 1;
            6'h03: return 2;
            6'h04: return 5;
            6'h08, 6'h0A: return 6;
            6'h23: return 7;
            6'h2B: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h22: return 3'b110;
                6'h24: return 3'b000;
                6'h25: return 3'b001;
                6'h2A: return 3'b111;
                default: return 3'b010;
            endcase
            6'h04: return 3'b110;
            6'h0A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic set_idle_exp(input logic h, input logic b);
        exp_valid = 1'b1; exp_sel = 1'b0;
        exp_imem_req = 1'b0; exp_dmem_rd = 1'b0; exp_dmem_wr = 1'b0;
        exp_pc_en = 1'b0; exp_reg_write = 1'b0; exp_halted = h; exp_bus_err = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int iwait, input int dwait,
                             output int pc_cycle, output int rd_cnt);
        int cls, f, ms, me, lat;
        logic wr;
        cls = cls_of(op, fn);
        f  = iwait + 1;
        ms = f + 3;
        me = ms + dwait;
        case (cls)
            1, 2:    lat = f + 1;
            3, 5:    lat = f + 2;
            8:       lat = me;
            7:       lat = me + 1;
            default: lat = f + 3;
        endcase
        wr = (cls == 2 || cls == 4 || cls == 6 || cls == 7);
        opcode = op; funct = fn; zero = z;
        pc_cycle = 0; rd_cnt = 0;
        for (int k = 1; k <= lat; k++) begin
            imem_ack = (k == f);
            dmem_ack = (cls == 7 || cls == 8) && (k == me);
            set_idle_exp(1'b0, 1'b0);
            exp_imem_req  = (k <= f);
            exp_dmem_rd   = (cls == 7) && (k >= ms) && (k <= me);
            exp_dmem_wr   = (cls == 8) && (k >= ms) && (k <= me);
            exp_pc_en     = (k == lat);
            exp_reg_write = (k == lat) && wr;
            exp_sel       = (k == lat);
            exp_j         = (cls == 1 || cls == 2) ? 2'b01 : (cls == 3) ? 2'b10 : 2'b00;
            exp_pc_src    = (cls == 5) ? z : 1'b0;
            exp_alu_src   = (cls >= 6);
            exp_m2r       = (cls == 7);
            exp_chk_rd    = wr;
            exp_reg_dst   = (cls == 2) ? 2'b10 : (cls == 4) ? 2'b01 : 2'b00;
            exp_write_dst = (cls == 2);
            exp_chk_alu   = (cls >= 4);
            exp_alu       = alu_of(op, fn);
            @(negedge clk);
            if (pc_en) pc_cycle = k;
            if (dmem_rd) rd_cnt++;
            step();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", 8'(imem_req), 8'd0);
        check("rst_pc_en",    8'(pc_en),    8'd0);
        check("rst_reg_write", 8'(reg_write), 8'd0);
        check("rst_halted",   8'(halted),   8'd0);
        check("rst_sels", 8'({reg_dst, J, alu_ctrl, pc_src}), 8'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rel_imem_req", 8'(imem_req), 8'd0);
        step();
    endtask

    int pcc, rdc, req_cnt;

    initial begin
        do_reset();

        // Hand-computed latencies pin the timeline model.
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, pcc, rdc);
        check("add_latency", 8'(pcc), 8'd4);
        run_instr(6'h00, 6'h22, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h00, 6'h24, 1'b0, 1, 0, pcc, rdc);
        run_instr(6'h00, 6'h25, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h0A, 6'h11, 1'b0, 2, 0, pcc, rdc);

        run_instr(6'h23, 6'h00, 1'b0, 0, 3, pcc, rdc);
        check("lw_wait_latency", 8'(pcc), 8'd8);
        check("lw_wait_rd_cycles", 8'(rdc), 8'd4);
        run_instr(6'h23, 6'h00, 1'b0, 0, 0, pcc, rdc);
        check("lw_latency", 8'(pcc), 8'd5);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, pcc, rdc);
        check("sw_latency", 8'(pcc), 8'd4);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 2, pcc, rdc);
        run_instr(6'h23, 6'h00, 1'b0, 0, TO - 1, pcc, rdc);

        run_instr(6'h04, 6'h00, 1'b1, 0, 0, pcc, rdc);
        check("beq_latency", 8'(pcc), 8'd3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, pcc, rdc);
        run_instr(6'h03, 6'h00, 1'b0, 0, 0, pcc, rdc);
        check("jal_latency", 8'(pcc), 8'd2);

        // Ack on the expiry cycle completes normally.
        run_instr(6'h00, 6'h20, 1'b0, TO - 1, 0, pcc, rdc);
        check("late_ack_latency", 8'(pcc), 8'd7);

        // Fetch timeout; acks during HALT must be ignored.
        req_cnt = 0;
        for (int k = 1; k <= int'(TO); k++) begin
            set_idle_exp(1'b0, 1'b0);
            exp_imem_req = 1'b1;
            @(negedge clk);
            if (imem_req) req_cnt++;
            step();
        end
        check("timeout_req_cycles", 8'(req_cnt), 8'd4);
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1;
            set_idle_exp(1'b1, 1'b1);
            step();
        end
        do_reset();

        // Illegal opcode: DECODE then HALT without bus error.
        opcode = 6'h3F; funct = 6'h00;
        imem_ack = 1'b1;
        set_idle_exp(1'b0, 1'b0);
        exp_imem_req = 1'b1;
        step();
        imem_ack = 1'b0;
        set_idle_exp(1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            set_idle_exp(1'b1, 1'b0);
            step();
        end
        do_reset();

        // Reset in the middle of an sw data wait: no commit.
        opcode = 6'h2B; funct = 6'h00;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        step();
        step();
        @(negedge clk);
        check("sw_mem_wr", 8'(dmem_wr), 8'd1);
        step();
        #1;
        rst = 1'b0;
        #1;
        dmem_ack = 1'b1;
        #1;
        check("abort_dmem_wr", 8'(dmem_wr), 8'd0);
        check("abort_pc_en", 8'(pc_en), 8'd0);
        check("abort_reg_write", 8'(reg_write), 8'd0);
        dmem_ack = 1'b0;
        do_reset();
        run_instr(6'h00, 6'h25, 1'b0, 0, 0, pcc, rdc);
        check("post_reset_latency", 8'(pcc), 8'd4);

        exp_valid = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
